// File: rtl/mem_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : mem_axi_sram_slave
// Purpose  : AXI slave over on-chip data SRAM; single-beat reads/writes with
//            independent read/write FSMs and programmable response latency.
// Revision : 1.0
// ============================================================================
module mem_axi_sram_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RD_LATENCY  = 2,
  parameter int          WR_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  // read address / data
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arsize,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  // write address / data / response
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int RCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int WCNT_W = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;
  localparam logic [31:0]       SPAN_BYTES = 32'(8 * DEPTH_WORDS);
  localparam logic [RCNT_W-1:0] RCNT_INIT  = RCNT_W'(RD_LATENCY - 1);
  localparam logic [WCNT_W-1:0] WCNT_INIT  = WCNT_W'(WR_LATENCY - 1);
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  logic [63:0] mem [DEPTH_WORDS];

  // Offset wraps below BASE_ADDR, so one unsigned compare covers both bounds.
  function automatic logic access_ok(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    logic [3:0]  span_end;
    off      = addr - BASE_ADDR;
    span_end = {1'b0, addr[2:0]} + (4'd1 << size[1:0]);
    return (off < SPAN_BYTES) && (size <= 3'd2) && (span_end <= 4'd8);
  endfunction

  // ---------------------------------------------------------------- read path
  rd_state_e         rstate_q, rstate_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [31:0]       araddr_q, araddr_d;
  logic [2:0]        arsize_q, arsize_d;
  logic              rvalid_q, rvalid_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       roff;
  logic [IDX_W-1:0]  ridx;
  logic              rd_ok;

  assign roff  = araddr_q - BASE_ADDR;
  assign ridx  = roff[IDX_W+2:3];
  assign rd_ok = access_ok(araddr_q, arsize_q);

  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (arvalid) begin
          araddr_d = araddr;
          arsize_d = arsize;
          rcnt_d   = RCNT_INIT;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rdata_d  = rd_ok ? mem[ridx] : 64'd0;
          rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rvalid_d = 1'b1;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign arready = (rstate_q == R_IDLE);
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // --------------------------------------------------------------- write path
  wr_state_e         wstate_q, wstate_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [3:0]        bid_q, bid_d;
  logic [31:0]       woff;
  logic [IDX_W-1:0]  widx;
  logic              wr_hs;
  logic              wr_ok;

  assign woff  = awaddr - BASE_ADDR;
  assign widx  = woff[IDX_W+2:3];
  assign wr_hs = (wstate_q == W_IDLE) && awvalid && wvalid;
  assign wr_ok = access_ok(awaddr, awsize) && (awlen == 8'd0) && wlast && (wstrb != 8'd0);

  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    case (wstate_q)
      W_IDLE: begin
        if (wr_hs) begin
          bid_d    = awid;
          bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
          wcnt_d   = WCNT_INIT;
          wstate_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          bvalid_d = 1'b1;
          wstate_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q <= W_IDLE;
      wcnt_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      bid_q    <= '0;
    end else begin
      wstate_q <= wstate_d;
      wcnt_q   <= wcnt_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
    end
  end

  // Storage is not reset; the rst term blocks a commit while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wr_hs && wr_ok) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign awready = wr_hs;
  assign wready  = wr_hs;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, awburst, roff[31:IDX_W+3], roff[2:0],
                       woff[31:IDX_W+3], woff[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_axi_sram_slave
// Purpose  : Directed + randomized bench for mem_axi_sram_slave against a
//            word-array reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_axi_sram_slave;

  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr;
  logic [3:0]  awid, bid;
  logic [7:0]  awlen, wstrb;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [63:0] wdata;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model_mem [int];

  always #5 clk = ~clk;

  mem_axi_sram_slave #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit acc_legal(input logic [31:0] addr, input logic [2:0] size);
    longint off;
    off = longint'({32'd0, addr}) - longint'({32'd0, BASE});
    return (off >= 0) && (off < 8 * DEPTH) && (size <= 2) &&
           ((int'(addr[2:0]) + (1 << size)) <= 8);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - BASE) >> 3);
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                    input logic [2:0] size, input logic [3:0] id, input logic [7:0] len,
                    input logic last, input int aw_lead);
    bit legal;
    int lat;
    int w;
    legal = acc_legal(addr, size) && (len == 0) && last && (strb != 0);
    @(negedge clk);
    awaddr = addr; awsize = size; awid = id; awlen = len; awburst = 2'b01;
    wdata = data; wstrb = strb; wlast = last;
    awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      #1;
      check("aw_alone_awready", awready, 0);
      check("aw_alone_wready", wready, 0);
      @(negedge clk);
    end
    wvalid = 1'b1;
    #1;
    check("awready", awready, 1);
    check("wready", wready, 1);
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (legal) begin
      w = word_of(addr);
      for (int b = 0; b < 8; b++)
        if (strb[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
    end
    lat = 0;
    while (!bvalid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("b_latency", lat, WR_LAT);
    check("bresp", bresp, legal ? 2'b00 : 2'b10);
    check("bid", bid, id);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clear", bvalid, 0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size, input string tag);
    bit legal;
    logic [63:0] exp_d;
    int lat;
    legal = acc_legal(addr, size);
    exp_d = legal ? model_mem[word_of(addr)] : 64'd0;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arsize = size;
    #1;
    check({tag, "_arready"}, arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, lat, RD_LAT);
    check({tag, "_rdata"}, rdata, exp_d);
    check({tag, "_rresp"}, rresp, legal ? 2'b00 : 2'b10);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check({tag, "_rvalid_clear"}, rvalid, 0);
  endtask

  initial begin
    logic [63:0] exp_d;
    logic [63:0] old_d;
    logic [63:0] new_d;
    int lat;

    rst = 1'b0;
    arvalid = 0; araddr = 0; arsize = 0; rready = 0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    check("rst_bid", bid, 0);
    @(negedge clk);
    rst = 1'b1;

    // Known contents for the first 16 words.
    for (int i = 0; i < 16; i++)
      wr(BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 3'd2, 4'(i), 8'd0, 1'b1, 0);

    wr(BASE + 32'd4, 64'h1122_3344_0000_0000, 8'hF0, 3'd2, 4'd5, 8'd0, 1'b1, 0);
    rd(BASE, 3'd2, "upper_word");
    wr(BASE + 32'd3, 64'h0000_0000_AB00_0000, 8'h08, 3'd0, 4'd3, 8'd0, 1'b1, 0);
    rd(BASE, 3'd2, "byte3");

    // rready held low while a write goes through.
    exp_d = model_mem[2];
    @(negedge clk);
    arvalid = 1'b1; araddr = BASE + 32'd16; arsize = 3'd2;
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("stall_lat", lat, RD_LAT);
    wr(BASE + 32'd24, {$urandom, $urandom}, 8'hFF, 3'd2, 4'd7, 8'd0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_rvalid", rvalid, 1);
      check("stall_rdata", rdata, exp_d);
      check("stall_arready", arready, 0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("stall_release", rvalid, 0);

    // Illegal requests.
    rd(32'h7FFF_FFF8, 3'd2, "below_base");
    rd(BASE + 32'(8 * DEPTH), 3'd0, "above_top");
    rd(BASE, 3'd3, "arsize3");
    rd(BASE + 32'd6, 3'd2, "rd_cross");
    wr(BASE + 32'd8, {$urandom, $urandom}, 8'hFF, 3'd2, 4'd1, 8'd1, 1'b1, 0);
    rd(BASE + 32'd8, 3'd2, "after_awlen1");
    wr(BASE + 32'd7, {$urandom, $urandom}, 8'h80, 3'd1, 4'd2, 8'd0, 1'b1, 0);
    wr(BASE + 32'd8, {$urandom, $urandom}, 8'h00, 3'd2, 4'd4, 8'd0, 1'b1, 0);
    wr(BASE + 32'd8, {$urandom, $urandom}, 8'h0F, 3'd2, 4'd6, 8'd0, 1'b0, 0);
    rd(BASE + 32'd8, 3'd2, "after_bad_writes");

    // Lone awvalid must not be accepted.
    wr(BASE + 32'd32, {$urandom, $urandom}, 8'h0F, 3'd2, 4'd9, 8'd0, 1'b1, 3);
    rd(BASE + 32'd32, 3'd2, "after_lone_aw");

    // Read sample and write commit to the same word on the same edge.
    old_d = model_mem[5];
    new_d = {$urandom, $urandom};
    @(negedge clk);
    arvalid = 1'b1; araddr = BASE + 32'd40; arsize = 3'd2;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    awaddr = BASE + 32'd40; awsize = 3'd2; awid = 4'd2; awlen = 8'd0; awburst = 2'b01;
    wdata = new_d; wstrb = 8'hFF; wlast = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("rbw_rvalid", rvalid, 1);
    check("rbw_old_data", rdata, old_d);
    model_mem[5] = new_d;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rbw_bvalid", bvalid, 1);
    check("rbw_bresp", bresp, 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    rd(BASE + 32'd40, 3'd2, "rbw_new_data");

    // Reset while the read is waiting.
    @(negedge clk);
    arvalid = 1'b1; araddr = BASE; arsize = 3'd2;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rvalid", rvalid, 0);
    check("abort_arready", arready, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_resp", rvalid, 0);
    end
    rd(BASE, 3'd2, "after_abort");

    // Randomized mix over the initialised region plus out-of-range hits.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic [7:0]  strb;
      a  = BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        a = $urandom_range(0, 1) ? BASE - 32'(8 * $urandom_range(1, 4))
                                 : BASE + 32'(8 * DEPTH) + 32'(8 * $urandom_range(0, 3));
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        rd(a, sz, "rnd_rd");
      end else begin
        strb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        wr(a, {$urandom, $urandom}, strb, sz, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0,
           ($urandom_range(0, 9) != 0), 0);
      end
    end
    for (int i = 0; i < 16; i++)
      rd(BASE + 32'(8 * i), 3'd2, "final_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_axi_sram_slave.md
Name: mem_axi_sram_slave

Overview:
AXI responder modelling on-chip data SRAM, the slave end of the data-memory master port. Accepts AXI-lite single reads with a size field and AXI-full single-beat writes (AW+W presented together, B response with ID echo). Returns full aligned 64-bit words; the master shifts by addr[2:0]. Read and write channels run independently, each with its own state machine and programmable latency.

Parameters:
DEPTH_WORDS, 1024, number of 64-bit storage words (power of 2)
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LATENCY, 2, cycles from AR handshake to rvalid (>=1)
WR_LATENCY, 1, cycles from AW/W handshake to bvalid (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  32  read byte address
arsize  in  3  read size (0=byte, 1=half, 2=word)
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  64  aligned 64-bit word
rresp  out  2  00 OKAY, 10 SLVERR
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  32  write byte address
awid  in  4  write ID
awlen  in  8  burst length - 1
awsize  in  3  write size
awburst  in  2  burst type (ignored)
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  64  lane-placed write data
wstrb  in  8  byte enables
wlast  in  1  last beat
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  00 OKAY, 10 SLVERR
bid  out  4  echoed awid

Behaviour:
- Reset (rst=0, async): both FSMs -> IDLE; rvalid, bvalid=0; rdata=0, rresp=0, bresp=0, bid=0; latency counters=0. Storage not reset.
- Index = (addr - BASE_ADDR) >> 3; in range iff BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS.
- Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
  - arready = R_IDLE. Handshake (arvalid&arready): latch araddr/arsize, load counter with RD_LATENCY-1, go R_WAIT.
  - R_WAIT: decrement each cycle; at counter 0, the edge samples storage into rdata, sets rresp, and moves to R_RESP with rvalid=1. RD_LATENCY=1 gives rvalid the cycle after the handshake.
  - Error (rresp=10, rdata=0): address out of range, arsize>2, or addr[2:0]+(1<<arsize) > 8.
  - R_RESP: rvalid, rdata, rresp held stable until rready; on rvalid&rready -> R_IDLE, rvalid=0. No new AR accepted before return to R_IDLE (one outstanding read).
- Write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
  - awready = wready = W_IDLE & awvalid & wvalid. AW and W are accepted only together; a lone valid is not accepted and must stay asserted.
  - Handshake: latch awid into bid. If legal, commit the bytes with wstrb[i]=1 to storage at this edge; other bytes are unchanged.
  - Illegal write: out of range, awlen!=0, wlast=0, awsize>2, size crossing 8-byte boundary, or wstrb=0. Storage is not modified and bresp=10; otherwise bresp=00.
  - W_WAIT counts WR_LATENCY-1 like the read path, then W_RESP with bvalid=1. bvalid, bresp, bid held until bready; handshake -> W_IDLE.
- Simultaneous read sample and write commit to the same word on the same edge: the read returns pre-write data (read-before-write). A later read sees the new data.
- Channels are fully independent; a stalled rready never blocks writes and vice versa.
- Reset asserted mid-transaction aborts it with no response. A write committed at an earlier edge stays committed.

Test Plan:
- Reset, then write 0x1122_3344 to 0x8000_0004 (wdata=0x1122_3344_0000_0000, wstrb=0xF0, awsize=2, awid=5) -> awready=wready=1 same cycle; bvalid 1 cycle later; bresp=00, bid=5.
- Read 0x8000_0000, arsize=2, RD_LATENCY=2, rready=1 -> rvalid exactly 2 cycles after handshake; rdata=0x1122_3344_xxxx_xxxx with the low word unchanged; rresp=00.
- Byte write 0xAB to 0x8000_0003 (wstrb=0x08), then read the word -> only byte 3 changes, to 0xAB.
- Hold rready=0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout; write completes meanwhile.
- Illegal requests: read 0x7FFF_FFF8 -> rresp=10, rdata=0. Write with awlen=1 -> bresp=10, storage unchanged. Half write at 0x8000_0007 -> bresp=10.
- Assert awvalid alone for 3 cycles, then wvalid -> no ready until both high. Drop rst during R_WAIT -> rvalid stays 0, FSM returns to R_IDLE.
